// File: rtl/occupancy_pkg.sv
// Shared types and default timing for the multi-zone occupancy absence timer.
package occupancy_pkg;

  typedef enum logic [1:0] {
    INICIAL  = 2'd0,
    CONTANDO = 2'd1,
    WARN     = 2'd2,
    EXPIRE   = 2'd3
  } zone_state_t;

  localparam int DEFAULT_N_ZONES   = 4;
  localparam int DEFAULT_TIMEOUT_T = 30000;
  localparam int DEFAULT_WARN_T    = 5000;
  localparam int DEFAULT_CNT_W     = 16;

endpackage

// File: rtl/zone_timer.sv
// One zone's absence timer: counts while enabled and idle, warns, then pulses shutdown.
module zone_timer
  import occupancy_pkg::*;
#(
  parameter int TIMEOUT_T = DEFAULT_TIMEOUT_T,
  parameter int WARN_T    = DEFAULT_WARN_T,
  parameter int CNT_W     = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic enable_i,
  input  logic infravermelho_i,
  output logic c_o,
  output logic warn_o,
  output logic active_o
);

  if (!((2 ** CNT_W) > TIMEOUT_T)) begin : g_cnt_w_check
    $error("zone_timer: CNT_W too narrow to hold TIMEOUT_T");
  end
  if (!(WARN_T >= 0 && WARN_T < TIMEOUT_T && TIMEOUT_T >= 2)) begin : g_timing_check
    $error("zone_timer: need 0 <= WARN_T < TIMEOUT_T and TIMEOUT_T >= 2");
  end

  localparam logic [CNT_W-1:0] WARN_START = CNT_W'(TIMEOUT_T - WARN_T - 1);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(TIMEOUT_T - 1);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  zone_state_t      state_q, state_d;
  logic [CNT_W-1:0] tc_q, tc_d;
  logic             abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INICIAL;
      tc_q    <= '0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
    end
  end

  // Presence or disable always wins over the terminal count.
  assign abort = infravermelho_i | ~enable_i;

  always_comb begin
    state_d = state_q;
    tc_d    = tc_q;
    case (state_q)
      INICIAL: begin
        tc_d = '0;
        if (enable_i && !infravermelho_i) state_d = CONTANDO;
      end
      CONTANDO: begin
        if (abort) begin
          state_d = INICIAL;
          tc_d    = '0;
        end else if (tc_q == WARN_START) begin
          if (WARN_T > 0) begin
            state_d = WARN;
            tc_d    = tc_q + ONE;
          end else begin
            state_d = EXPIRE;
            tc_d    = '0;
          end
        end else begin
          tc_d = tc_q + ONE;
        end
      end
      WARN: begin
        if (abort) begin
          state_d = INICIAL;
          tc_d    = '0;
        end else if (tc_q == LAST_CNT) begin
          state_d = EXPIRE;
          tc_d    = '0;
        end else begin
          tc_d = tc_q + ONE;
        end
      end
      EXPIRE: begin
        state_d = INICIAL;
        tc_d    = '0;
      end
      default: begin
        state_d = INICIAL;
        tc_d    = '0;
      end
    endcase
  end

  assign c_o      = (state_q == EXPIRE);
  assign warn_o   = (state_q == WARN);
  assign active_o = (state_q == CONTANDO) || (state_q == WARN);

endmodule

// File: rtl/occupancy_timeout_multi.sv
// N independent zone absence timers plus aggregate shutdown and active-count status.
module occupancy_timeout_multi
  import occupancy_pkg::*;
#(
  parameter int N_ZONES   = DEFAULT_N_ZONES,
  parameter int TIMEOUT_T = DEFAULT_TIMEOUT_T,
  parameter int WARN_T    = DEFAULT_WARN_T,
  parameter int CNT_W     = DEFAULT_CNT_W,
  localparam int NA_W     = $clog2(N_ZONES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_ZONES-1:0] enable,
  input  logic [N_ZONES-1:0] infravermelho,
  output logic [N_ZONES-1:0] C,
  output logic [N_ZONES-1:0] warn,
  output logic [N_ZONES-1:0] active,
  output logic               any_shutdown,
  output logic [NA_W-1:0]    n_active
);

  for (genvar gi = 0; gi < N_ZONES; gi++) begin : g_zone
    zone_timer #(
      .TIMEOUT_T(TIMEOUT_T),
      .WARN_T   (WARN_T),
      .CNT_W    (CNT_W)
    ) u_zone (
      .clk            (clk),
      .rst            (rst),
      .enable_i       (enable[gi]),
      .infravermelho_i(infravermelho[gi]),
      .c_o            (C[gi]),
      .warn_o         (warn[gi]),
      .active_o       (active[gi])
    );
  end

  assign any_shutdown = |C;

  always_comb begin
    n_active = '0;
    for (int i = 0; i < N_ZONES; i++) begin
      n_active = n_active + NA_W'(active[i]);
    end
  end

endmodule

// File: tb/tb_occupancy_timeout_multi.sv
// Scoreboard bench: stimulus queues timestamped expectations, a negedge monitor checks them.
module tb_occupancy_timeout_multi;

  localparam int NZ = 4;
  localparam int TT = 10;
  localparam int WT = 3;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NZ-1:0] en0 = '0, inf0 = '0, en1 = '0, inf1 = '0;
  logic [NZ-1:0] c0, w0, a0, c1, w1, a1;
  logic          any0, any1;
  logic [2:0]    n0, n1;

  occupancy_timeout_multi #(.N_ZONES(NZ), .TIMEOUT_T(TT), .WARN_T(WT), .CNT_W(CW)) dut0 (
    .clk(clk), .rst(rst), .enable(en0), .infravermelho(inf0),
    .C(c0), .warn(w0), .active(a0), .any_shutdown(any0), .n_active(n0)
  );

  occupancy_timeout_multi #(.N_ZONES(NZ), .TIMEOUT_T(TT), .WARN_T(0), .CNT_W(CW)) dut1 (
    .clk(clk), .rst(rst), .enable(en1), .infravermelho(inf1),
    .C(c1), .warn(w1), .active(a1), .any_shutdown(any1), .n_active(n1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    int          dut;
    logic [15:0] v;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [15:0] pack(logic [3:0] c, logic [3:0] w, logic [3:0] a);
    return {c, w, a, |c, 3'($countones(a))};
  endfunction

  task automatic push(string name, int at, int dut, logic [3:0] c, logic [3:0] w, logic [3:0] a);
    exp_t e;
    int   idx;
    e.at = at; e.dut = dut; e.v = pack(c, w, a); e.name = name;
    idx = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].at > at) begin idx = i; break; end
    end
    sb.insert(idx, e);
  endtask

  function automatic void check(string name, int dut, logic [15:0] exp_v);
    logic [15:0] got;
    got = (dut == 1) ? {c1, w1, a1, any1, n1} : {c0, w0, a0, any0, n0};
    n_checks++;
    if (got === exp_v) begin
      n_pass++;
      $display("check %s dut%0d cyc %0d {C,warn,active,any,n}=%h ok", name, dut, cyc, got);
    end else begin
      $display("FAIL %s dut%0d cyc %0d: got {C,warn,active,any,n}=%h expected %h",
               name, dut, cyc, got, exp_v);
    end
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.at < cyc) begin
        n_checks++;
        $display("FAIL %s dut%0d: expectation for cyc %0d missed at cyc %0d", e.name, e.dut, e.at, cyc);
      end else begin
        check(e.name, e.dut, e.v);
      end
    end
  end

  task automatic wait_to(int c);
    while (cyc < c) @(negedge clk);
    #1;
  endtask

  int s, k, k2, guard;

  initial begin
    // Reset held for two edges, then released between edges with all inputs idle.
    push("rst_c1", 1, 0, 4'h0, 4'h0, 4'h0);
    push("rst_c1_w0", 1, 1, 4'h0, 4'h0, 4'h0);
    push("rst_c2", 2, 0, 4'h0, 4'h0, 4'h0);
    wait_to(2);
    rst = 1'b0;
    push("post_rst", 3, 0, 4'h0, 4'h0, 4'h0);
    push("post_rst_w0", 3, 1, 4'h0, 4'h0, 4'h0);
    wait_to(4);

    // Basic timeout on zone 0.
    s = cyc; k = s + 1; en0[0] = 1'b1;
    push("A_start", k,      0, 4'h0, 4'h0, 4'h1);
    push("A_cnt6",  k + 6,  0, 4'h0, 4'h0, 4'h1);
    push("A_warn7", k + 7,  0, 4'h0, 4'h1, 4'h1);
    push("A_warn9", k + 9,  0, 4'h0, 4'h1, 4'h1);
    push("A_C",     k + 10, 0, 4'h1, 4'h0, 4'h0);
    push("A_idle",  k + 11, 0, 4'h0, 4'h0, 4'h0);
    push("A_rearm", k + 12, 0, 4'h0, 4'h0, 4'h1);
    push("A_off",   k + 13, 0, 4'h0, 4'h0, 4'h0);
    wait_to(k + 12); en0[0] = 1'b0;
    wait_to(k + 15);

    // Retrigger on zone 1: presence at count 5 restarts the full window.
    s = cyc; k = s + 1; en0[1] = 1'b1;
    push("B_cnt5",  k + 5, 0, 4'h0, 4'h0, 4'h2);
    push("B_abort", k + 6, 0, 4'h0, 4'h0, 4'h0);
    k2 = k + 7;
    push("B_restart", k2,      0, 4'h0, 4'h0, 4'h2);
    push("B_nowarn",  k2 + 6,  0, 4'h0, 4'h0, 4'h2);
    push("B_warn9",   k2 + 9,  0, 4'h0, 4'h2, 4'h2);
    push("B_C",       k2 + 10, 0, 4'h2, 4'h0, 4'h0);
    push("B_off",     k2 + 11, 0, 4'h0, 4'h0, 4'h0);
    wait_to(k + 5);  inf0[1] = 1'b1;
    wait_to(k + 6);  inf0[1] = 1'b0;
    wait_to(k2 + 10); en0[1] = 1'b0;
    wait_to(k2 + 13);

    // Zone 2: presence exactly at Tc==TIMEOUT_T-1, then enable drop in WARN.
    s = cyc; k = s + 1; en0[2] = 1'b1;
    push("C_warn9",  k + 9,  0, 4'h0, 4'h4, 4'h4);
    push("C_noC",    k + 10, 0, 4'h0, 4'h0, 4'h0);
    k2 = k + 11;
    push("C_rearm",  k2,     0, 4'h0, 4'h0, 4'h4);
    push("C_warn8",  k2 + 8, 0, 4'h0, 4'h4, 4'h4);
    push("C_dis",    k2 + 9, 0, 4'h0, 4'h0, 4'h0);
    push("C_dis_noC", k2 + 10, 0, 4'h0, 4'h0, 4'h0);
    wait_to(k + 9);  inf0[2] = 1'b1;
    wait_to(k + 10); inf0[2] = 1'b0;
    wait_to(k2 + 8); en0[2] = 1'b0;
    wait_to(k2 + 12);

    // All four zones, staggered starts.
    s = cyc; en0[0] = 1'b1; en0[1] = 1'b1;
    push("D_n2",   s + 1,  0, 4'h0, 4'h0, 4'h3);
    push("D_n2b",  s + 2,  0, 4'h0, 4'h0, 4'h3);
    push("D_n3",   s + 3,  0, 4'h0, 4'h0, 4'h7);
    push("D_n4",   s + 4,  0, 4'h0, 4'h0, 4'hF);
    push("D_w01",  s + 8,  0, 4'h0, 4'h3, 4'hF);
    push("D_w012", s + 10, 0, 4'h0, 4'h7, 4'hF);
    push("D_C01",  s + 11, 0, 4'h3, 4'hC, 4'hC);
    push("D_gap",  s + 12, 0, 4'h0, 4'hC, 4'hC);
    push("D_C2",   s + 13, 0, 4'h4, 4'h8, 4'h8);
    push("D_C3",   s + 14, 0, 4'h8, 4'h0, 4'h0);
    push("D_idle", s + 16, 0, 4'h0, 4'h0, 4'h0);
    wait_to(s + 2);  en0[2] = 1'b1;
    wait_to(s + 3);  en0[3] = 1'b1;
    wait_to(s + 11); en0[0] = 1'b0; en0[1] = 1'b0;
    wait_to(s + 13); en0[2] = 1'b0;
    wait_to(s + 14); en0[3] = 1'b0;
    wait_to(s + 17);

    // Asynchronous reset pulse between edges while zone 0 is in WARN.
    s = cyc; k = s + 1; en0[0] = 1'b1;
    push("E_warn", k + 8, 0, 4'h0, 4'h1, 4'h1);
    wait_to(k + 8);
    rst = 1'b1; #1;
    check("E_rst_async", 0, pack(4'h0, 4'h0, 4'h0));
    #1; rst = 1'b0; #1;
    check("E_rst_released", 0, pack(4'h0, 4'h0, 4'h0));
    k2 = k + 9;
    push("E_restart", k2,      0, 4'h0, 4'h0, 4'h1);
    push("E_rwarn",   k2 + 7,  0, 4'h0, 4'h1, 4'h1);
    push("E_rC",      k2 + 10, 0, 4'h1, 4'h0, 4'h0);
    wait_to(k2 + 10); en0[0] = 1'b0;
    wait_to(k2 + 12);

    // WARN_T=0 build: no warning, pulse after the full window.
    s = cyc; k = s + 1; en1[0] = 1'b1;
    push("F_start",  k,      1, 4'h0, 4'h0, 4'h1);
    push("F_cnt5",   k + 5,  1, 4'h0, 4'h0, 4'h1);
    push("F_cnt9",   k + 9,  1, 4'h0, 4'h0, 4'h1);
    push("F_C",      k + 10, 1, 4'h1, 4'h0, 4'h0);
    push("F_idle",   k + 11, 1, 4'h0, 4'h0, 4'h0);
    wait_to(k + 10); en1[0] = 1'b0;
    wait_to(k + 12);

    guard = 0;
    while (sb.size() > 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      $display("FAIL %s dut%0d: expectation for cyc %0d never reached", e.name, e.dut, e.at);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
